// File: rtl/count_event_pkg.sv
// count_event_pkg: event type codes, record field offsets and record width helper
package count_event_pkg;
  localparam logic [1:0] EVT_NONE  = 2'b00;
  localparam logic [1:0] EVT_MATCH = 2'b01;
  localparam logic [1:0] EVT_WRAP  = 2'b10;
  localparam logic [1:0] EVT_BOTH  = 2'b11;
  localparam int CNT_LSB = 0;
  function automatic int epoch_lsb(input int cw);
    return cw;
  endfunction
  function automatic int type_lsb(input int cw, input int epw);
    return cw + epw;
  endfunction
  function automatic int evt_w(input int cw, input int epw);
    return 2 + epw + cw;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: pointer FIFO with occupancy, full/valid flags and same-cycle push+pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    level = wr_q - rd_q;
    valid = level != '0;
    full = level[AW];
    do_pop = pop && valid;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    dout = valid ? mem_q[rd_q[AW-1:0]] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/count_event_fifo.sv
// count_event_fifo: detects counter wrap / compare-match events, stamps them with a wrap epoch and queues them
module count_event_fifo
  import count_event_pkg::*;
#(
  parameter int CW    = 4,
  parameter int EPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CW-1:0]                 count_in,
  input  logic                          match_en,
  input  logic [CW-1:0]                 match_val,
  input  logic                          clr_ovf,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [evt_w(CW,EPW)-1:0]      evt_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow
);
  localparam int W = evt_w(CW, EPW);
  logic [CW-1:0] prev_q, prev_d;
  logic primed_q, primed_d;
  logic [EPW-1:0] epoch_q, epoch_d;
  logic ovf_q, ovf_d;
  logic wrap, match, push, pop, drop, full;
  logic [1:0] typ;
  logic [W-1:0] rec;
  always_comb begin
    wrap = primed_q && (&prev_q) && count_in == '0;
    match = primed_q && match_en && count_in == match_val && count_in != prev_q;
    typ = {wrap, match};
    push = typ != EVT_NONE;
    epoch_d = epoch_q + EPW'(wrap);
    rec = {typ, epoch_d, count_in};
    prev_d = count_in;
    primed_d = 1'b1;
    pop = evt_valid && evt_ready;
    drop = push && full && !pop;
    ovf_d = drop || (ovf_q && !clr_ovf);
    overflow = ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      primed_q <= 1'b0;
      epoch_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      primed_q <= primed_d;
      epoch_q <= epoch_d;
      ovf_q <= ovf_d;
    end
  end
  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(rec), .pop(evt_ready),
    .dout(evt_data), .valid(evt_valid), .full(full), .level(level)
  );
endmodule

// File: tb/tb_count_event_fifo.sv
// tb_count_event_fifo: scoreboard bench; a reference FIFO model predicts every output each cycle
module tb_count_event_fifo;
  logic clk = 0, rst = 1;
  logic [3:0] count_in = 0, match_val = 0;
  logic match_en = 0, clr_ovf = 0, evt_ready = 0;
  logic evt_valid, overflow;
  logic [9:0] evt_data;
  logic [2:0] level;
  int total = 0, bad = 0, peak = 0;
  logic [9:0] q[$];
  logic [9:0] dut_pops[$];
  logic [3:0] m_prev, m_epoch;
  logic m_primed, m_ovf;

  count_event_fifo dut (
    .clk(clk), .rst(rst), .count_in(count_in), .match_en(match_en), .match_val(match_val),
    .clr_ovf(clr_ovf), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = 0; m_primed = 0; m_epoch = 0; m_ovf = 0;
  endtask

  // called at negedge with inputs already set; checks outputs, then advances the model one edge
  task automatic step();
    logic w, m, push, pop, drop;
    logic [3:0] ep;
    chk("valid", evt_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("ovf", overflow, m_ovf);
    if (q.size() != 0) chk("data", evt_data, q[0]);
    if (int'(level) > peak) peak = level;
    if (evt_valid && evt_ready) dut_pops.push_back(evt_data);
    w = m_primed && m_prev == 4'hf && count_in == 0;
    m = m_primed && match_en && count_in == match_val && count_in != m_prev;
    ep = m_epoch + 4'(w);
    push = w || m;
    pop = q.size() != 0 && evt_ready;
    drop = push && q.size() == 4 && !pop;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (pop) void'(q.pop_front());
      if (push && q.size() < 4) q.push_back({w, m, ep, count_in});
      m_ovf = drop || (m_ovf && !clr_ovf);
      m_prev = count_in; m_primed = 1; m_epoch = ep;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      count_in = i[0] ? 4'ha : 4'h5;
      step();
    end
    rst = 0;
    count_in = 0;
    // free run 0..15,0,1 with match on 5
    match_en = 1; match_val = 5; evt_ready = 1;
    for (int i = 0; i < 18; i++) begin
      count_in = 4'(i);
      step();
    end
    step();
    chk("t2_npops", dut_pops.size(), 2);
    if (dut_pops.size() >= 2) begin
      chk("t2_match", dut_pops[0], {2'b01, 4'd0, 4'd5});
      chk("t2_wrap", dut_pops[1], {2'b10, 4'd1, 4'd0});
    end
    // match_val=0 coincident with wrap -> one combined entry
    dut_pops.delete(); match_val = 0; peak = 0;
    for (int i = 2; i < 17; i++) begin
      count_in = 4'(i);
      step();
    end
    step(); step();
    chk("t3_npops", dut_pops.size(), 1);
    if (dut_pops.size() >= 1) chk("t3_both", dut_pops[0], {2'b11, 4'd2, 4'd0});
    chk("t3_peak", peak, 1);
    // five wraps with no consumer: fifth dropped
    dut_pops.delete(); match_en = 0; evt_ready = 0;
    for (int i = 0; i < 5; i++) begin
      count_in = 4'hf; step();
      count_in = 4'h0; step();
    end
    chk("t4_level", level, 4);
    chk("t4_ovf", overflow, 1);
    clr_ovf = 1; step(); clr_ovf = 0;
    chk("t4_clr", overflow, 0);
    // full with simultaneous push and pop
    count_in = 4'hf; step();
    count_in = 4'h0; evt_ready = 1; step();
    chk("t5_level", level, 4);
    chk("t5_ovf", overflow, 0);
    for (int i = 0; i < 6; i++) step();
    chk("t4_npops", dut_pops.size(), 5);
    if (dut_pops.size() >= 5) begin
      for (int k = 0; k < 4; k++) chk("t4_order", dut_pops[k], {2'b10, 4'(k + 3), 4'd0});
      chk("t5_entry", dut_pops[4], {2'b10, 4'd8, 4'd0});
    end
    // stalled count yields one match, then reset with three queued entries
    evt_ready = 0; match_en = 1; match_val = 5;
    for (int i = 0; i < 6; i++) begin
      count_in = 4'h5; step();
    end
    chk("t6_stall", level, 1);
    count_in = 4'hf; step();
    count_in = 4'h0; step();
    count_in = 4'h5; step();
    chk("t6_level3", level, 3);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_data", evt_data, 0);
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 0;
    dut_pops.delete(); evt_ready = 1;
    count_in = 4'h5; step();
    count_in = 4'h6; step();
    count_in = 4'hf; step();
    count_in = 4'h0; step();
    step(); step();
    chk("t6_npops", dut_pops.size(), 1);
    if (dut_pops.size() >= 1) chk("t6_epoch", dut_pops[0], {2'b10, 4'd1, 4'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
